round_core_sched: RTL and testbench

Round-robin scheduler that shares one iterative round-core datapath and its controller among `N_REQ` requesters. It sits between the requester ports and the core controller's `start`/`Done` pair. It grants one requester at a time and drives the operand/result mux select. It pulses the core start, watches for completion with a timeout watchdog, and returns a done or error pulse to the granted requester.

---
 rtl/round_core_sched_pkg.sv | 15 +
 rtl/round_core_sched_rr_pick.sv | 29 ++
 rtl/round_core_sched.sv | 99 +++++++++
 tb/tb_round_core_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/round_core_sched_pkg.sv
// Shared definitions for the round-robin core scheduler: FSM state encoding
// and the default watchdog limit.
package round_core_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } sched_state_t;

    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/round_core_sched_rr_pick.sv
// Combinational wrap-around priority search: first set request at or above
// ptr, otherwise the lowest set request below ptr.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [SEL_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Descending scans leave the lowest hit; the upper region overrides the wrapped one.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (j < int'(i_ptr))) begin
                o_idx = SEL_W'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (j >= int'(i_ptr))) begin
                o_idx = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/round_core_sched.sv
// Round-robin scheduler sharing one iterative core among N_REQ requesters,
// with start/done handshake and a timeout watchdog.
module round_core_sched
    import round_core_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [N_REQ-1:0] o_job_done,
    output logic [N_REQ-1:0] o_job_err,
    output logic [SEL_W-1:0] o_core_sel,
    output logic             o_core_start,
    input  logic             i_core_done,
    output logic             o_core_abort,
    output logic             o_busy
);

    sched_state_t     r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_wdog;
    logic             r_ok;

    logic             w_valid;
    logic [SEL_W-1:0] w_idx;
    logic [N_REQ-1:0] w_owner;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_wdog  <= '0;
            r_ok    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_sel   <= w_idx;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + CNT_W'(1);
                    // Completion takes precedence over a coincident timeout.
                    if (i_core_done) begin
                        r_ok    <= 1'b1;
                        r_state <= ST_RELEASE;
                    end else if (r_wdog == CNT_W'(TIMEOUT - 1)) begin
                        r_ok    <= 1'b0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_ptr   <= (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode: every output derives from registered state, sel and ok only.
    assign w_owner      = N_REQ'(1) << r_sel;
    assign o_gnt        = (r_state == ST_GRANT || r_state == ST_LAUNCH || r_state == ST_WAIT)
                          ? w_owner : '0;
    assign o_job_done   = (r_state == ST_RELEASE && r_ok)  ? w_owner : '0;
    assign o_job_err    = (r_state == ST_RELEASE && !r_ok) ? w_owner : '0;
    assign o_core_abort = (r_state == ST_RELEASE) && !r_ok;
    assign o_core_start = (r_state == ST_LAUNCH);
    assign o_core_sel   = r_sel;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_round_core_sched.sv
// Self-checking bench for round_core_sched: directed scenarios plus random
// traffic, compared every cycle against a job-level reference model.
module tb_round_core_sched;

    localparam int N_REQ   = 4;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] job_done;
    logic [N_REQ-1:0] job_err;
    logic [SEL_W-1:0] core_sel;
    logic             core_start;
    logic             core_done;
    logic             core_abort;
    logic             busy;

    always #5 clk = ~clk;

    round_core_sched #(
        .N_REQ   (N_REQ),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .o_gnt        (gnt),
        .o_job_done   (job_done),
        .o_job_err    (job_err),
        .o_core_sel   (core_sel),
        .o_core_start (core_start),
        .i_core_done  (core_done),
        .o_core_abort (core_abort),
        .o_busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a job is either absent, or alive with an age counted
    // from its grant cycle (0 = grant, 1 = launch, >=2 = waiting), or in its
    // one-cycle release with a success flag.
    bit m_busy  = 0;
    bit m_rel   = 0;
    bit m_ok    = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_age   = 0;

    int               done_after = 0;  // WAIT cycle (1-based) carrying core_done; 0 = never
    int               dut_grants[$];
    logic [N_REQ-1:0] prev_gnt = '0;

    function automatic int pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return 0;
    endfunction

    task automatic model_update(input logic [N_REQ-1:0] r, input logic d, input logic rs);
        if (rs) begin
            m_busy = 0; m_rel = 0; m_ok = 0; m_owner = 0; m_ptr = 0; m_age = 0;
        end else if (!m_busy) begin
            if (r != '0) begin
                m_owner = pick(r, m_ptr);
                m_busy  = 1; m_rel = 0; m_age = 0;
            end
        end else if (m_rel) begin
            m_busy = 0; m_rel = 0;
            m_ptr  = (m_owner + 1) % N_REQ;
        end else if (m_age >= 2 && d) begin
            m_rel = 1; m_ok = 1;
        end else if (m_age >= 2 && (m_age - 2) == TIMEOUT - 1) begin
            m_rel = 1; m_ok = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] eg, ed, ee;
        eg = '0; ed = '0; ee = '0;
        if (m_busy && !m_rel) eg = N_REQ'(1) << m_owner;
        if (m_rel && m_ok)    ed = N_REQ'(1) << m_owner;
        if (m_rel && !m_ok)   ee = N_REQ'(1) << m_owner;
        chk("gnt",        32'(gnt),        32'(eg));
        chk("job_done",   32'(job_done),   32'(ed));
        chk("job_err",    32'(job_err),    32'(ee));
        chk("core_abort", 32'(core_abort), 32'(m_rel && !m_ok));
        chk("core_start", 32'(core_start), 32'(m_busy && !m_rel && m_age == 1));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("core_sel",   32'(core_sel),   32'(m_owner));
    endtask

    task automatic cycle(input logic [N_REQ-1:0] r, input logic rs, input logic stray);
        req       = r;
        rst       = rs;
        core_done = stray || (m_busy && !m_rel && m_age >= 2 && done_after != 0
                              && (m_age - 1) == done_after);
        @(posedge clk);
        model_update(r, core_done, rs);
        #1;
        check_outputs();
        if (gnt != '0 && prev_gnt == '0) begin
            for (int k = 0; k < N_REQ; k++) if (gnt[k]) dut_grants.push_back(k);
        end
        prev_gnt = gnt;
    endtask

    initial begin
        logic [N_REQ-1:0] rq;
        logic [N_REQ-1:0] seen_bits;
        int  lat;
        int  wcount;
        bit  started;
        bit  hit;
        bit  aborted;

        req = '0; rst = 1'b1; core_done = 1'b0;
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0);

        // Single requester, done on the 5th WAIT cycle
        rq = 4'b0001; done_after = 5; lat = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle(rq, 1'b0, 1'b0);
            if (i == 1) chk("single_gnt_t1", 32'(gnt), 32'h1);
            if (i == 2) chk("single_start_t2", 32'(core_start), 32'h1);
            if (job_done != '0) begin lat = i; rq &= ~job_done; break; end
        end
        chk("single_done_latency", 32'(lat), 32'd8);
        cycle(rq, 1'b0, 1'b0);
        chk("single_busy_d2", 32'(busy), 32'h0);

        // Fairness with all four requests held
        cycle('0, 1'b1, 1'b0);
        dut_grants.delete();
        done_after = 3;
        for (int i = 0; i < 200 && dut_grants.size() < 5; i++) cycle(4'hF, 1'b0, 1'b0);
        chk("fair_grant_count", 32'(dut_grants.size() >= 5), 32'h1);
        for (int k = 0; k < 5 && k < dut_grants.size(); k++) chk("fair_order", 32'(dut_grants[k]), 32'(k % N_REQ));
        for (int i = 0; i < 15; i++) cycle('0, 1'b0, 1'b0);

        // Timeout: core never completes
        rq = 4'b0010; done_after = 0; wcount = 0; started = 0; hit = 0; seen_bits = '0; aborted = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(rq, 1'b0, 1'b0);
            if (job_done != '0) seen_bits = job_done;
            if (job_err != '0) begin hit = 1; aborted = core_abort; rq &= ~job_err; break; end
            if (started && gnt != '0) wcount++;
            if (core_start) started = 1;
        end
        chk("timeout_seen", 32'(hit), 32'h1);
        chk("timeout_wait_cycles", 32'(wcount), 32'(TIMEOUT));
        chk("timeout_abort", 32'(aborted), 32'h1);
        chk("timeout_no_done", 32'(seen_bits), 32'h0);
        cycle(rq, 1'b0, 1'b0);

        // Done on the last WAIT cycle beats the timeout
        rq = 4'b0100; done_after = TIMEOUT; seen_bits = '0; aborted = 0; hit = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(rq, 1'b0, 1'b0);
            if (core_abort || job_err != '0) aborted = 1;
            if (job_done != '0) begin seen_bits = job_done; rq &= ~job_done; break; end
        end
        chk("race_done", 32'(seen_bits), 32'h4);
        chk("race_no_abort", 32'(aborted), 32'h0);
        cycle(rq, 1'b0, 1'b0);

        // Request dropped mid-WAIT, then stray core_done in IDLE
        rq = 4'b1000; done_after = 6; seen_bits = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) rq = '0;
            cycle(rq, 1'b0, 1'b0);
            if (job_done != '0) begin seen_bits = job_done; break; end
        end
        chk("drop_done", 32'(seen_bits), 32'h8);
        cycle('0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_gnt", 32'(gnt), 32'h0);

        // Reset while waiting
        rq = 4'b0001; done_after = 0;
        for (int i = 0; i < 6; i++) cycle(rq, 1'b0, 1'b0);
        chk("rst_pre_busy", 32'(busy), 32'h1);
        cycle(rq, 1'b1, 1'b0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(core_sel), 32'h0);
        rq = 4'b0100; done_after = 2;
        cycle(rq, 1'b0, 1'b0);
        chk("rst_regrant", 32'(gnt), 32'h4);
        for (int i = 0; i < 12; i++) begin
            cycle(rq, 1'b0, 1'b0);
            rq &= ~(job_done | job_err);
        end

        // Random traffic
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            if (m_busy && !m_rel && m_age == 0) done_after = int'($urandom_range(0, 70));
            if ($urandom_range(0, 3) == 0)  rq |= N_REQ'($urandom);
            if ($urandom_range(0, 49) == 0) rq &= N_REQ'($urandom);
            cycle(rq, 1'b0 || ($urandom_range(0, 199) == 0), $urandom_range(0, 9) == 0);
            rq &= ~(job_done | job_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
